// File: rtl/sdf_ctrl_pkg.sv
// rtl/sdf_ctrl_pkg.sv - shared encodings for the SDF stage sequencer
package sdf_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_FILL = 2'd0,
    SEL_BF   = 2'd1,
    SEL_TW   = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sdf_phase_counter.sv
// rtl/sdf_phase_counter.sv - position within a 2*DELAY block, wraps to 0, flags the second half
module sdf_phase_counter #(
  parameter int DELAY   = 8,
  parameter int PHASE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               half
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      if (phase_q == PHASE_W'(2*DELAY-1)) phase_d = '0;
      else                                phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;
  assign half  = (phase_q >= PHASE_W'(DELAY));

endmodule

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - radix-2 SDF FFT stage sequencer: mux select, twiddle index, drain, frame tracking
// Optional macro SDF_CTRL_IFFT_EN adds the inverse input and the tw_conj output.
module sdf_stage_ctrl
  import sdf_ctrl_pkg::*;
#(
  parameter int DELAY   = 8,
  parameter int PHASE_W = 4,
  parameter int FRAME_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
`ifdef SDF_CTRL_IFFT_EN
  input  logic               inverse,
  output logic               tw_conj,
`endif
  output logic               in_ready,
  output logic [1:0]         stage_sel,
  output logic [PHASE_W-2:0] tw_addr,
  output logic               out_valid,
  output logic               frame_done,
  output logic               last_err,
  output logic [FRAME_W-1:0] sample_cnt
);

  state_e             state_q, state_d;
  sel_e               sel_q, sel_d;
  logic [PHASE_W-2:0] tw_addr_q, tw_addr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               last_err_q, last_err_d;
  logic [FRAME_W-1:0] sample_cnt_q, sample_cnt_d;

  logic [PHASE_W-1:0] phase;
  logic               half;
  logic               ph_en;
  logic               ph_clr;
  logic               accept;

  assign accept = in_valid & in_ready_q;

  // During DRAIN the same counter is reused as the drain index 0..DELAY-1.
  sdf_phase_counter #(
    .DELAY  (DELAY),
    .PHASE_W(PHASE_W)
  ) u_phase (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ph_en),
    .clr  (ph_clr),
    .phase(phase),
    .half (half)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tw_addr_d    = tw_addr_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    last_err_d   = last_err_q;
    sample_cnt_d = sample_cnt_q;
    ph_en        = 1'b0;
    ph_clr       = 1'b0;

    case (state_q)
      DRAIN: begin
        if (half) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
          ph_clr       = 1'b1;
          sample_cnt_d = '0;
        end else begin
          ph_en       = 1'b1;
          out_valid_d = 1'b1;
          sel_d       = SEL_TW;
          tw_addr_d   = phase[PHASE_W-2:0];
        end
      end
      default: begin
        // in_ready stays low through the frame_done cycle and returns one cycle later
        if (state_q == IDLE) in_ready_d = 1'b1;
        if (accept) begin
          ph_en = 1'b1;
          if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + FRAME_W'(1);
          if (state_q == RUN) begin
            out_valid_d = 1'b1;
            if (half) begin
              sel_d = SEL_BF;
            end else begin
              sel_d     = SEL_TW;
              tw_addr_d = phase[PHASE_W-2:0];
            end
          end else begin
            sel_d = SEL_FILL;
            if (state_q == IDLE)                     state_d = FILL;
            else if (phase == PHASE_W'(DELAY-1))     state_d = RUN;
          end
          if (in_last) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
            ph_clr     = 1'b1;
            if (phase != PHASE_W'(2*DELAY-1)) last_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= SEL_FILL;
      tw_addr_q    <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      last_err_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tw_addr_q    <= tw_addr_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      last_err_q   <= last_err_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

`ifdef SDF_CTRL_IFFT_EN
  logic tw_conj_q, tw_conj_d;

  always_comb begin
    tw_conj_d = tw_conj_q;
    if (state_q == IDLE && accept) tw_conj_d = inverse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tw_conj_q <= 1'b0;
    else        tw_conj_q <= tw_conj_d;
  end

  assign tw_conj = tw_conj_q;
`endif

  assign in_ready   = in_ready_q;
  assign stage_sel  = sel_q;
  assign tw_addr    = tw_addr_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign last_err   = last_err_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - self-checking bench for sdf_stage_ctrl at DELAY=8
module tb_sdf_stage_ctrl;

  localparam int DELAY   = 8;
  localparam int PHASE_W = 4;
  localparam int FRAME_W = 11;
  localparam int CNT_MAX = (1 << FRAME_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic [1:0]         stage_sel;
  logic [PHASE_W-2:0] tw_addr;
  logic               out_valid;
  logic               frame_done;
  logic               last_err;
  logic [FRAME_W-1:0] sample_cnt;
`ifdef SDF_CTRL_IFFT_EN
  logic inverse = 1'b0;
  logic tw_conj;
  bit   m_conj;
`endif

  int n_checks = 0;
  int n_errs = 0;
  int cycle = 0;
  int done_seen = 0;

  // reference model state: frame position is the count of accepted samples
  bit m_ready, m_ov, m_done, m_err, m_pend, m_recover;
  int m_sel, m_addr, m_cnt, m_nacc, m_drain;

  typedef struct {
    bit v;
    bit l;
    bit rdy;
    int sel;
    int addr;
    bit ov;
    bit done;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.DELAY(DELAY), .PHASE_W(PHASE_W), .FRAME_W(FRAME_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
`ifdef SDF_CTRL_IFFT_EN
    .inverse   (inverse),
    .tw_conj   (tw_conj),
`endif
    .in_ready  (in_ready),
    .stage_sel (stage_sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .last_err  (last_err),
    .sample_cnt(sample_cnt)
  );

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_ready = 1; m_ov = 0; m_done = 0; m_err = 0; m_pend = 0; m_recover = 0;
    m_sel = 0; m_addr = 0; m_cnt = 0; m_nacc = 0; m_drain = 0;
`ifdef SDF_CTRL_IFFT_EN
    m_conj = 0;
`endif
  endtask

  task automatic model_step(input bit v, input bit l);
    bit acc;
    int pos;
    acc = v && m_ready;
    m_ov = 0;
    m_done = 0;
    if (m_drain > 0) begin
      m_sel = 2; m_addr = DELAY - m_drain; m_ov = 1;
      m_drain--;
      if (m_drain == 0) m_pend = 1;
    end else if (m_pend) begin
      m_pend = 0; m_done = 1; m_cnt = 0; m_nacc = 0; m_recover = 1;
    end else if (m_recover) begin
      m_recover = 0; m_ready = 1;
    end else if (acc) begin
      pos = m_nacc % (2*DELAY);
`ifdef SDF_CTRL_IFFT_EN
      if (m_nacc == 0) m_conj = inverse;
`endif
      if (m_nacc < DELAY) begin
        m_sel = 0;
      end else begin
        m_ov = 1;
        if (pos < DELAY) begin m_sel = 2; m_addr = pos; end
        else m_sel = 1;
      end
      m_nacc++;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (l) begin
        m_ready = 0; m_drain = DELAY;
        if (pos != 2*DELAY-1) m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, m_ready);
    check("stage_sel", stage_sel, m_sel);
    check("tw_addr", tw_addr, m_addr);
    check("out_valid", out_valid, m_ov);
    check("frame_done", frame_done, m_done);
    check("last_err", last_err, m_err);
    check("sample_cnt", sample_cnt, m_cnt);
`ifdef SDF_CTRL_IFFT_EN
    check("tw_conj", tw_conj, m_conj);
`endif
  endtask

  task automatic cyc(input bit v, input bit l);
    in_valid = v;
    in_last = l;
    @(posedge clk);
    cycle++;
    model_step(v, l);
    #1;
    if (frame_done) done_seen++;
    compare_all();
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_last = 0;
    rst_n = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    cycle++;
    #1;
    compare_all();
    rst_n = 1;
  endtask

  initial begin
    int d0;
    bit v, l;

    for (int i = 0; i < 32; i++) begin
      vec_t e;
      e.v = 1; e.l = (i == 31); e.rdy = (i != 31); e.cnt = i + 1; e.done = 0;
      if (i < 8)       begin e.sel = 0; e.ov = 0; e.addr = 0; end
      else if (i < 16) begin e.sel = 1; e.ov = 1; e.addr = 0; end
      else if (i < 24) begin e.sel = 2; e.ov = 1; e.addr = i - 16; end
      else             begin e.sel = 1; e.ov = 1; e.addr = 7; end
      tbl.push_back(e);
    end
    for (int j = 0; j < 8; j++) tbl.push_back('{1'b0, 1'b0, 1'b0, 2, j, 1'b1, 1'b0, 32});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2, 7, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 0});

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst_n = 1;

    // full frame, back-to-back samples
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_last = tbl[i].l;
      @(posedge clk);
      cycle++;
      #1;
      check("t1_in_ready", in_ready, tbl[i].rdy);
      check("t1_stage_sel", stage_sel, tbl[i].sel);
      check("t1_tw_addr", tw_addr, tbl[i].addr);
      check("t1_out_valid", out_valid, tbl[i].ov);
      check("t1_frame_done", frame_done, tbl[i].done);
      check("t1_last_err", last_err, 0);
      check("t1_sample_cnt", sample_cnt, tbl[i].cnt);
    end

    // same frame with a gap after every sample
    do_reset();
    d0 = done_seen;
    for (int i = 0; i < 32; i++) begin
      cyc(1, i == 31);
      cyc(0, 0);
    end
    repeat (10) cyc(0, 0);
    check("t2_done_count", done_seen - d0, 1);

    // early in_last at position 12
    do_reset();
    d0 = done_seen;
    repeat (12) cyc(1, 0);
    cyc(1, 1);
    check("t3_last_err_set", last_err, 1);
    repeat (10) cyc(0, 0);
    check("t3_done_count", done_seen - d0, 1);
    check("t3_last_err_sticky", last_err, 1);

    // reset mid-RUN at position 5
    do_reset();
    repeat (21) cyc(1, 0);
    d0 = done_seen;
    do_reset();
    cyc(1, 0);
    check("t4_restart_sel", stage_sel, 0);
    check("t4_restart_cnt", sample_cnt, 1);
    repeat (20) cyc(0, 0);
    check("t4_no_done", done_seen - d0, 0);

    // in_valid held high through drain
    do_reset();
    repeat (31) cyc(1, 0);
    cyc(1, 1);
    repeat (8) cyc(1, 0);
    check("t5_cnt_frozen", sample_cnt, 32);
    cyc(1, 0);
    check("t5_done", frame_done, 1);
    cyc(1, 0);
    cyc(1, 0);
    check("t5_fill_sel", stage_sel, 0);
    check("t5_fill_ov", out_valid, 0);
    check("t5_fill_cnt", sample_cnt, 1);

    // counter saturation
    do_reset();
    repeat (2060) cyc(1, 0);
    check("sat_cnt", sample_cnt, CNT_MAX);
    cyc(1, 1);
    repeat (11) cyc(0, 0);

`ifdef SDF_CTRL_IFFT_EN
    do_reset();
    inverse = 1;
    cyc(1, 0);
    for (int i = 0; i < 40; i++) begin
      inverse = $urandom_range(0, 1);
      cyc(1, i == 39);
    end
    check("ifft_conj_held", tw_conj, 1);
    repeat (11) cyc(0, 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 9) < 7);
      l = v && (($urandom_range(0, 39) == 0) ||
                ((m_nacc % (2*DELAY)) == 2*DELAY-1 && $urandom_range(0, 2) == 0));
`ifdef SDF_CTRL_IFFT_EN
      inverse = $urandom_range(0, 1);
`endif
      cyc(v, l);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
